// File: rtl/rv32_muldiv_pkg.sv
// Shared op encodings, FSM state type and op-classification helpers for the
// radix-2 RV32M multiply/divide unit.
package rv32_muldiv_ops;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed1(input logic [2:0] op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_signed2(input logic [2:0] op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/rv32_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. hi holds the accumulator/partial remainder, lo the multiplier/quotient.
module rv32_muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            div_mode,
   input  logic [XLEN-1:0] hi_in,
   input  logic [XLEN-1:0] lo_in,
   input  logic [XLEN-1:0] operand_in,
   output logic [XLEN-1:0] hi_out,
   output logic [XLEN-1:0] lo_out
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            fits;

   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand_in} : '0);
      shifted = {hi_in, lo_in[XLEN-1]};
      fits    = shifted >= {1'b0, operand_in};
      // when the divisor fits, the true difference is below 2^XLEN
      diff    = shifted[XLEN-1:0] - operand_in;
      if (div_mode) begin
         hi_out = fits ? diff : shifted[XLEN-1:0];
         lo_out = {lo_in[XLEN-2:0], fits};
      end else begin
         hi_out = sum[XLEN:1];
         lo_out = {sum[0], lo_in[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/rv32_muldiv.sv
// Multi-cycle RV32M multiply/divide unit with handshake, flush and early-out.
// Optional RV32_MULDIV_FAST_MUL_EN: multiplies complete in one cycle.
module rv32_muldiv
   import rv32_muldiv_ops::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            valid_in,
   input  logic [2:0]      op_in,
   input  logic [XLEN-1:0] rs1_value_in,
   input  logic [XLEN-1:0] rs2_value_in,
   input  logic            flush_in,
   output logic            ready_out,
   output logic            valid_out,
   output logic [XLEN-1:0] result_out
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   logic [2:0]      op_q;
   logic [XLEN-1:0] hi_q, lo_q, opnd_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_q, ready_q, done_q;

   logic            accept, sign1, sign2, neg_in, div_zero, div_ovf;
   logic [XLEN-1:0] abs1, abs2, step_hi, step_lo;

   always_comb begin
      accept   = valid_in && ready_q && !flush_in;
      sign1    = is_signed1(op_in) && rs1_value_in[XLEN-1];
      sign2    = is_signed2(op_in) && rs2_value_in[XLEN-1];
      abs1     = sign1 ? -rs1_value_in : rs1_value_in;
      abs2     = sign2 ? -rs2_value_in : rs2_value_in;
      neg_in   = (op_in == REM) ? sign1 : (sign1 ^ sign2);
      div_zero = is_div(op_in) && (rs2_value_in == '0);
      div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                 (rs1_value_in == SMIN) && (rs2_value_in == '1);
   end

`ifdef RV32_MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fm_a, fm_b;
   logic signed [2*XLEN+1:0] fm_p;

   always_comb begin
      fm_a = signed'({is_signed1(op_in) && rs1_value_in[XLEN-1], rs1_value_in});
      fm_b = signed'({is_signed2(op_in) && rs2_value_in[XLEN-1], rs2_value_in});
      fm_p = fm_a * fm_b;
   end
`endif

   rv32_muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode   (is_div(op_q)),
      .hi_in      (hi_q),
      .lo_in      (lo_q),
      .operand_in (opnd_q),
      .hi_out     (step_hi),
      .lo_out     (step_lo)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q <= op_in;
                  if (div_zero || div_ovf) begin
                     // quotient lands in lo, remainder in hi; no sign fix-up
                     lo_q    <= div_zero ? '1 : rs1_value_in;
                     hi_q    <= div_zero ? rs1_value_in : '0;
                     neg_q   <= 1'b0;
                     state   <= DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
`ifdef RV32_MULDIV_FAST_MUL_EN
                  end else if (!is_div(op_in)) begin
                     {hi_q, lo_q} <= fm_p[2*XLEN-1:0];
                     neg_q   <= 1'b0;
                     state   <= DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
`endif
                  end else begin
                     hi_q    <= '0;
                     lo_q    <= is_div(op_in) ? abs1 : abs2;
                     opnd_q  <= is_div(op_in) ? abs2 : abs1;
                     neg_q   <= neg_in;
                     cnt_q   <= CW'(XLEN - 1);
                     state   <= CALC;
                     ready_q <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (flush_in) begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
               end else begin
                  hi_q  <= step_hi;
                  lo_q  <= step_lo;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   res;

   always_comb begin
      prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      case (op_q)
         MUL:                  res = prod[XLEN-1:0];
         MULH, MULHSU, MULHU:  res = prod[2*XLEN-1:XLEN];
         DIV, DIVU:            res = neg_q ? -lo_q : lo_q;
         default:              res = neg_q ? -hi_q : hi_q;
      endcase
      ready_out  = ready_q;
      valid_out  = done_q && !flush_in;
      result_out = valid_out ? res : '0;
   end

endmodule

// File: tb/tb_rv32_muldiv.sv
// Directed self-checking bench for rv32_muldiv (XLEN=32).
module tb_rv32_muldiv;
   import rv32_muldiv_ops::*;

`ifdef RV32_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [2:0]  op_in = '0;
   logic [31:0] rs1_value_in = '0;
   logic [31:0] rs2_value_in = '0;
   logic        flush_in = 1'b0;
   logic        ready_out, valid_out;
   logic [31:0] result_out;

   int passed = 0;
   int total  = 0;

   rv32_muldiv #(.XLEN(32)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid_in     (valid_in),
      .op_in        (op_in),
      .rs1_value_in (rs1_value_in),
      .rs2_value_in (rs2_value_in),
      .flush_in     (flush_in),
      .ready_out    (ready_out),
      .valid_out    (valid_out),
      .result_out   (result_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   // Issue one op and poll for the result pulse; cycle 0 is the accept edge.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic rdy_low);
      @(negedge clk);
      valid_in = 1'b1; op_in = op; rs1_value_in = a; rs2_value_in = b;
      @(posedge clk);
      #1 valid_in = 1'b0;
      res = '0; lat = -1; rdy_low = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (ready_out) rdy_low = 1'b0;
         if (valid_out) begin
            res = result_out; lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #12;
      total++; if (ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_out); else passed++;
      total++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else passed++;
      total++; if (result_out !== 32'h0) $display("FAIL reset_result: got %h want 0", result_out); else passed++;
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_mul;
      logic [31:0] res; int lat; logic rl;
      run_op(MUL, 32'd7, 32'hFFFFFFFD, res, lat, rl);
      total++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h want ffffffeb", res); else passed++;
      total++; if (lat != MUL_LAT) $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); else passed++;
      total++; if (rl !== 1'b1) $display("FAIL mul_ready_low: got ready high during op, want low"); else passed++;
      @(negedge clk);
      total++; if (valid_out !== 1'b0 || ready_out !== 1'b1)
         $display("FAIL mul_pulse_end: got valid=%b ready=%b want valid=0 ready=1", valid_out, ready_out);
      else passed++;
   endtask

   task automatic test_table(input string tag, input vec_t v[4], input int n);
      logic [31:0] res; int lat; logic rl;
      for (int i = 0; i < n; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, res, lat, rl);
         total++; if (res !== v[i].exp)
            $display("FAIL %s_result[%0d]: got %h want %h", tag, i, res, v[i].exp);
         else passed++;
         total++; if (lat != v[i].lat)
            $display("FAIL %s_latency[%0d]: got %0d want %0d", tag, i, lat, v[i].lat);
         else passed++;
      end
   endtask

   task automatic test_mulh;
      vec_t v[4];
      v[0] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
      v[1] = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
      v[2] = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
      v[3] = '{MUL,    32'd7,        32'd6,        32'd42,       MUL_LAT};
      test_table("mulh", v, 4);
   endtask

   task automatic test_div;
      vec_t v[4];
      v[0] = '{DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
      v[1] = '{REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
      v[2] = '{DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33};
      v[3] = '{REMU, 32'd100,      32'd7, 32'd2,        33};
      test_table("div", v, 4);
   endtask

   task automatic test_early_out;
      vec_t v[4];
      v[0] = '{DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      v[1] = '{REMU, 32'd5,        32'd0,        32'd5,        1};
      v[2] = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      v[3] = '{REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
      test_table("early", v, 4);
   endtask

   task automatic test_flush;
      logic saw = 1'b0;
      logic [31:0] res; int lat;
      @(negedge clk);
      valid_in = 1'b1; op_in = DIV; rs1_value_in = 32'd100; rs2_value_in = 32'd7;
      @(posedge clk);
      #1 valid_in = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (valid_out) saw = 1'b1;
         if (k == 10) flush_in = 1'b1;
      end
      @(negedge clk);
      total++; if (ready_out !== 1'b1) $display("FAIL flush_idle: got ready=%b want 1", ready_out); else passed++;
      total++; if (saw || valid_out !== 1'b0) $display("FAIL flush_no_valid: got valid pulse, want none"); else passed++;
      // back-to-back op accepted in cycle 11
      flush_in = 1'b0;
      valid_in = 1'b1; op_in = DIVU; rs1_value_in = 32'd100; rs2_value_in = 32'd7;
      @(posedge clk);
      #1 valid_in = 1'b0;
      res = '0; lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (valid_out) begin res = result_out; lat = k; break; end
      end
      total++; if (res !== 32'd14) $display("FAIL b2b_result: got %h want 0000000e", res); else passed++;
      total++; if (lat != 33) $display("FAIL b2b_latency: got %0d want 33", lat); else passed++;
   endtask

   task automatic test_flush_done;
      @(negedge clk);
      valid_in = 1'b1; op_in = DIVU; rs1_value_in = 32'd5; rs2_value_in = 32'd0;
      @(posedge clk);
      #1 valid_in = 1'b0; flush_in = 1'b1;
      @(negedge clk);
      total++; if (valid_out !== 1'b0) $display("FAIL flush_done_valid: got %b want 0", valid_out); else passed++;
      total++; if (result_out !== 32'h0) $display("FAIL flush_done_result: got %h want 0", result_out); else passed++;
      flush_in = 1'b0;
      @(negedge clk);
      total++; if (ready_out !== 1'b1) $display("FAIL flush_done_ready: got %b want 1", ready_out); else passed++;
      // valid_in together with flush_in must not be accepted
      valid_in = 1'b1; flush_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0; flush_in = 1'b0;
      @(negedge clk);
      total++; if (valid_out !== 1'b0 || ready_out !== 1'b1)
         $display("FAIL flush_blocks_accept: got valid=%b ready=%b want valid=0 ready=1", valid_out, ready_out);
      else passed++;
   endtask

   task automatic test_reset_midop;
      logic [31:0] res; int lat; logic rl;
      @(negedge clk);
      valid_in = 1'b1; op_in = MUL; rs1_value_in = 32'd7; rs2_value_in = 32'd6;
      @(posedge clk);
      #1 valid_in = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++; if (ready_out !== 1'b1) $display("FAIL midreset_ready: got %b want 1", ready_out); else passed++;
      total++; if (valid_out !== 1'b0) $display("FAIL midreset_valid: got %b want 0", valid_out); else passed++;
      total++; if (result_out !== 32'h0) $display("FAIL midreset_result: got %h want 0", result_out); else passed++;
      @(negedge clk); reset_n = 1'b1;
      run_op(MUL, 32'd7, 32'd6, res, lat, rl);
      total++; if (res !== 32'd42) $display("FAIL postreset_result: got %h want 0000002a", res); else passed++;
      total++; if (lat != MUL_LAT) $display("FAIL postreset_latency: got %0d want %0d", lat, MUL_LAT); else passed++;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_early_out();
      test_flush();
      test_flush_done();
      test_reset_midop();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rv32_muldiv.md
Name: rv32_muldiv

Overview:
Multi-cycle RV32M multiply/divide unit; sequential companion to the single-cycle integer ALU in the execute stage.
Accepts one op per handshake, iterates radix-2 (one bit per cycle), returns a single-cycle result pulse.
Generalised over XLEN. Adds handshake, flush and early-out, none of which the combinational ALU has.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64; counter width = $clog2(XLEN)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
valid_in  input  1  op request; accepted when valid_in && ready_out && !flush_in
op_in  input  3  RV32M op, funct3 encoding from package
rs1_value_in  input  XLEN  dividend / multiplicand
rs2_value_in  input  XLEN  divisor / multiplier
flush_in  input  1  abort in-flight op (pipeline flush)
ready_out  output  1  high only in IDLE
valid_out  output  1  one-cycle result pulse
result_out  output  XLEN  result; valid only while valid_out=1, otherwise 0

Behaviour:
- Reset: state=IDLE, ready_out=1, valid_out=0, result_out=0, all internal registers 0. Asynchronous assertion; release takes effect on the next clk edge.
- States: IDLE, CALC, DONE.
- IDLE→CALC on accept:
  - Latch |rs1| and |rs2|, using signedness per op: MULH/DIV/REM signed both; MULHSU signed rs1 only; others unsigned.
  - Latch negate flag: MUL*: sign1^sign2; DIV: sign1^sign2; REM: sign1.
  - Load counter=XLEN-1.
- IDLE→DONE directly on accept (early-out, latency 1):
  - Div/rem with rs2=0: DIV/DIVU result all-ones; REM/REMU result rs1 unchanged.
  - DIV/REM with rs1=signed min and rs2=-1: DIV result signed min; REM result 0.
- CALC, multiply: shift-add into a 2*XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle, partial remainder kept XLEN+1 bits wide.
- CALC→DONE when counter==0 on that edge; counter decrements every CALC cycle.
- DONE:
  - valid_out=1 for exactly one cycle.
  - result_out = low half (MUL), high half (MULH*), quotient (DIV*), remainder (REM*); two's-complement negated if the negate flag is set. MUL* negation is applied to the full 2*XLEN product before selecting the half.
  - Next edge → IDLE unconditionally. No back-pressure: the consumer must take the pulse.
- Latency: accept edge at cycle 0; valid_out in cycle XLEN+1 for iterative ops, cycle 1 for early-out. Throughput: one op per XLEN+2 cycles.
- flush_in:
  - In any state, next edge → IDLE; no valid_out for the aborted op.
  - flush_in with valid_in in IDLE: no accept.
  - flush_in in DONE: suppresses valid_out in that cycle (combinational gate).
- valid_in outside IDLE is ignored; the upstream stage holds it.
- reset_n low mid-op: immediate return to reset values; the op is lost.
- Unused op encodings: none; all 8 are defined.

Optional Feature:
Macro RV32_MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU compute in IDLE using a single XLEN x XLEN signed (XLEN+1)-bit extended multiply, register into the accumulator, and go IDLE→DONE (latency 1). Divides remain iterative.
- Undefined: all multiplies iterate XLEN cycles as above; no hardware multiplier is inferred.

Decomposition:
- Shared package rv32_muldiv_ops:
  - op localparams: MUL=3'b000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - State enum typedef.
  - Helpers is_div(op), is_signed1(op), is_signed2(op).
- Sub-module rv32_muldiv_step: combinational one-bit step, parametrised on XLEN; multiply add-shift and divide subtract-shift selected by a mode input. It is reused per CALC cycle.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3): valid_out in cycle 33, result 0xFFFFFFEB; ready_out low cycles 1-33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Early-out:
  - DIVU 5/0 → 0xFFFFFFFF at cycle 1; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1; REM same operands → 0.
- Start DIV, assert flush_in at cycle 10: state IDLE at cycle 11, no valid_out ever. Back-to-back new op accepted at cycle 11 completes correctly.
- Pull reset_n low at cycle 5 of a MUL: outputs immediately at reset values (ready_out=1, valid_out=0). With RV32_MULDIV_FAST_MUL_EN defined, MUL 7×6 → 42 at cycle 1.
